crc_stream_engine: RTL and testbench
====================================

Name: crc_stream_engine

Overview:
- Parametrised CRC generator/checker for framed parallel data. Successor to the serial 4-bit programmable-polynomial CRC.
- Consumes DATA_W bits per accepted beat over a valid/ready stream.
- Supports a runtime polynomial, initial value, input/output reflection and final XOR, with an optional compare against a received CRC.
- Sits between the framer/deframer and the link layer; one instance per channel.

Parameters:
CRC_W, 16, CRC register width; legal 2..32
DATA_W, 8, data bits consumed per accepted beat; legal 1..64
CNT_W, 16, width of the frame beat counter

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_poly  input  CRC_W  generator polynomial, implicit x^CRC_W term omitted
cfg_init  input  CRC_W  register value at frame start
cfg_xorout  input  CRC_W  final XOR value
cfg_refin  input  1  1 = each beat processed LSB first
cfg_refout  input  1  1 = bit-reverse register before final XOR
cfg_chk_en  input  1  1 = checker mode (compare against chk_crc)
in_valid  input  1  data beat valid
in_ready  output  1  engine accepts beat
in_data  input  DATA_W  data beat
in_last  input  1  final beat of frame, qualified by in_valid
in_abort  input  1  synchronous frame discard
chk_crc  input  CRC_W  expected CRC, sampled with the in_last beat
crc_valid  output  1  result available
crc_ready  input  1  result consumed
crc_out  output  CRC_W  final CRC
crc_error  output  1  checker mismatch, qualified by crc_valid
crc_beats  output  CNT_W  beats in the frame, saturating
busy  output  1  frame in progress (RUN or DONE)

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - crc_out, crc_error, crc_valid, crc_beats, busy and the internal register all go to 0.
  - in_ready=0 while rst_n is low, and 1 from the first clock after release.
- FSM states: IDLE, RUN, DONE.
- A beat is accepted when in_valid & in_ready. in_ready=1 in IDLE and RUN; in_ready=0 in DONE.
- IDLE:
  - On an accepted beat, latch all cfg_* inputs into shadow registers.
  - Process that first beat starting from cfg_init. Set the beat count to 1.
  - Go to RUN, or to DONE if in_last is set.
- RUN:
  - Each accepted beat updates the register and increments the count. The count saturates at all-ones.
  - A beat with in_last goes to DONE.
- Changing cfg_* mid-frame has no effect; only the shadow copies are used.
- Per-beat update: DATA_W serial steps in one cycle.
  - Bit order is in_data[DATA_W-1] down to [0] when refin=0, and [0] up to [DATA_W-1] when refin=1.
  - Each step: fb = r[CRC_W-1] ^ bit; r = {r[CRC_W-2:0],1'b0} ^ (fb ? poly : 0).
- Entering DONE (the edge that accepts the in_last beat):
  - crc_out = (refout ? bitrev(r_final) : r_final) ^ xorout.
  - crc_error = chk_en_shadow & (crc_out != chk_crc); chk_crc is the value sampled on that same beat.
  - crc_beats takes the final count.
  - crc_valid=1 in the next cycle, so latency is 1 clock from last-beat acceptance.
- DONE:
  - crc_valid, crc_out, crc_error and crc_beats hold stable until crc_valid & crc_ready.
  - On that handshake: crc_valid drops, state goes to IDLE, and in_ready rises in the following cycle. This costs one bubble cycle per frame.
  - crc_out, crc_beats and crc_error keep their last values after the handshake. crc_error reads 0 whenever chk_en_shadow=0.
- in_abort:
  - In RUN: go to IDLE next edge and discard the register and count. No crc_valid is produced.
  - If asserted with in_valid in the same cycle, abort wins and the beat is discarded. This holds in IDLE too, where the beat does not start a frame.
  - Ignored in DONE: the result is still delivered.
- Idle gaps (in_valid=0) in RUN hold all state.
- busy = (state != IDLE).
- Asynchronous reset mid-frame or mid-DONE drops the frame without a result.

Test Plan:
- CRC_W=16, DATA_W=8, poly 0x1021, init 0xFFFF, refin=0, refout=0, xorout 0; ASCII "123456789" as 9 beats -> crc_out=0x29B1, crc_beats=9, crc_valid 1 clock after the last beat.
- Same bytes with poly 0x8005, init 0, refin=1, refout=1, xorout 0 -> 0xBB3D. CRC_W=32, poly 0x04C11DB7, init and xorout 0xFFFFFFFF, refin=refout=1 -> 0xCBF43926.
- Checker mode with the first config: chk_crc=0x29B1 -> crc_error=0; chk_crc=0x29B0 -> crc_error=1. cfg_chk_en=0 with a mismatched chk_crc -> crc_error=0.
- Backpressure: hold crc_ready=0 for 5 cycles after the result -> crc_valid, crc_out and crc_error stable, in_ready=0. Release -> IDLE, and a back-to-back second frame is correct.
- Abort after 4 beats, including a cycle with in_abort & in_valid -> no crc_valid. The next "123456789" frame gives 0x29B1 and crc_beats=9. Toggling cfg_poly mid-frame does not change the result.
- Single-beat frame (in_last on the first beat) with byte 0x00, config 1 -> crc_out=0xE1F0, crc_beats=1. Asserting rst_n=0 mid-frame -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/crc_stream_engine.sv
// Parametrised CRC generator/checker over a valid/ready beat stream; DATA_W serial steps per beat.
// Result 1 clock after last-beat acceptance; held in DONE with in_ready=0 until crc_ready handshake.
module crc_stream_engine #(
    parameter int CRC_W  = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CRC_W-1:0]  cfg_poly,
    input  logic [CRC_W-1:0]  cfg_init,
    input  logic [CRC_W-1:0]  cfg_xorout,
    input  logic              cfg_refin,
    input  logic              cfg_refout,
    input  logic              cfg_chk_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_abort,
    input  logic [CRC_W-1:0]  chk_crc,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_error,
    output logic [CNT_W-1:0]  crc_beats,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q;
    logic [CRC_W-1:0]   crc_q, poly_q, xorout_q, crc_out_q;
    logic               refin_q, refout_q, chk_en_q;
    logic [CNT_W-1:0]   cnt_q, beats_q;
    logic               in_ready_q, crc_valid_q, crc_error_q;

    logic               accept, first;
    logic [CRC_W-1:0]   eff_poly, eff_xorout, crc_base, crc_d, res_d;
    logic               eff_refin, eff_refout, eff_chk_en, err_d;
    logic [CNT_W-1:0]   cnt_d;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0]  r_in,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic [CRC_W-1:0]  poly,
                                                  input logic              refin);
        logic [CRC_W-1:0] r;
        logic             b;
        logic             fb;
        r = r_in;
        for (int i = 0; i < DATA_W; i++) begin
            b  = refin ? d[i] : d[DATA_W-1-i];
            fb = r[CRC_W-1] ^ b;
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] o;
        for (int i = 0; i < CRC_W; i++) o[i] = v[CRC_W-1-i];
        return o;
    endfunction

    // The first beat of a frame is processed with the live cfg_* values, which are
    // latched into the shadows on that same edge; later beats use only the shadows.
    always_comb begin
        accept     = in_valid & in_ready_q;
        first      = (state_q == IDLE);
        eff_poly   = first ? cfg_poly   : poly_q;
        eff_xorout = first ? cfg_xorout : xorout_q;
        eff_refin  = first ? cfg_refin  : refin_q;
        eff_refout = first ? cfg_refout : refout_q;
        eff_chk_en = first ? cfg_chk_en : chk_en_q;
        crc_base   = first ? cfg_init   : crc_q;
        crc_d      = crc_step(crc_base, in_data, eff_poly, eff_refin);
        if (first)                   cnt_d = CNT_W'(1);
        else if (cnt_q == '1)        cnt_d = cnt_q;
        else                         cnt_d = cnt_q + CNT_W'(1);
        res_d      = (eff_refout ? bitrev(crc_d) : crc_d) ^ eff_xorout;
        err_d      = eff_chk_en & (res_d != chk_crc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            crc_q       <= '0;
            poly_q      <= '0;
            xorout_q    <= '0;
            refin_q     <= 1'b0;
            refout_q    <= 1'b0;
            chk_en_q    <= 1'b0;
            cnt_q       <= '0;
            beats_q     <= '0;
            crc_out_q   <= '0;
            crc_error_q <= 1'b0;
            crc_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    in_ready_q <= 1'b1;
                    if (in_abort) begin
                        state_q <= IDLE;
                        crc_q   <= '0;
                        cnt_q   <= '0;
                    end else if (accept) begin
                        if (first) begin
                            poly_q   <= cfg_poly;
                            xorout_q <= cfg_xorout;
                            refin_q  <= cfg_refin;
                            refout_q <= cfg_refout;
                            chk_en_q <= cfg_chk_en;
                        end
                        crc_q <= crc_d;
                        cnt_q <= cnt_d;
                        if (in_last) begin
                            state_q     <= DONE;
                            crc_out_q   <= res_d;
                            crc_error_q <= err_d;
                            beats_q     <= cnt_d;
                            crc_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                DONE: begin
                    if (crc_valid_q && crc_ready) begin
                        crc_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign crc_valid = crc_valid_q;
    assign crc_out   = crc_out_q;
    assign crc_error = crc_error_q;
    assign crc_beats = beats_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboarded bench for crc_stream_engine: 16-bit and 32-bit instances share one beat stream,
// reference CRCs come from polynomial long division of the augmented frame.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] poly16, init16, xor16, chk16;
    logic        refin16, refout16, chken16;
    logic [31:0] poly32, init32, xor32, chk32;
    logic        refin32, refout32, chken32;
    logic        in_valid, in_last, in_abort, crc_ready;
    logic [7:0]  in_data;

    logic        rdy16, rdy32, v16, v32, err16, err32, busy16, busy32;
    logic [15:0] out16, beats16, beats32;
    logic [31:0] out32;

    crc_stream_engine #(.CRC_W(16), .DATA_W(8), .CNT_W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .cfg_poly(poly16), .cfg_init(init16), .cfg_xorout(xor16),
        .cfg_refin(refin16), .cfg_refout(refout16), .cfg_chk_en(chken16),
        .in_valid(in_valid), .in_ready(rdy16), .in_data(in_data), .in_last(in_last),
        .in_abort(in_abort), .chk_crc(chk16), .crc_valid(v16), .crc_ready(crc_ready),
        .crc_out(out16), .crc_error(err16), .crc_beats(beats16), .busy(busy16));

    crc_stream_engine #(.CRC_W(32), .DATA_W(8), .CNT_W(16)) u32 (
        .clk(clk), .rst_n(rst_n), .cfg_poly(poly32), .cfg_init(init32), .cfg_xorout(xor32),
        .cfg_refin(refin32), .cfg_refout(refout32), .cfg_chk_en(chken32),
        .in_valid(in_valid), .in_ready(rdy32), .in_data(in_data), .in_last(in_last),
        .in_abort(in_abort), .chk_crc(chk32), .crc_valid(v32), .crc_ready(crc_ready),
        .crc_out(out32), .crc_error(err32), .crc_beats(beats32), .busy(busy32));

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [31:0] crc; logic err; logic [15:0] beats; } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb16[$];
    exp_t sb32[$];
    exp_t me16, me32, pe;
    bq_t  cur, kat, frm;
    logic in_frame = 1'b0;
    logic rand_rdy = 1'b0;

    logic [15:0] sp16, si16, sx16;
    logic        sri16, sro16, sce16;
    logic [31:0] sp32, si32, sx32;
    logic        sri32, sro32, sce32;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // CRC as the remainder of (M(x)*x^w + init*x^len) mod G(x), by long division on a bit array.
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly, input logic [31:0] init,
                                            input logic [31:0] xo, input logic ri, input logic ro,
                                            input bq_t msg);
        logic d[$];
        logic [31:0] r, o;
        int len;
        foreach (msg[k]) for (int j = 0; j < 8; j++) d.push_back(ri ? msg[k][j] : msg[k][7-j]);
        len = d.size();
        for (int j = 0; j < w; j++) d.push_back(1'b0);
        for (int j = 0; j < w; j++) d[j] = d[j] ^ init[w-1-j];
        for (int i = 0; i < len; i++)
            if (d[i]) for (int j = 1; j <= w; j++) d[i+j] = d[i+j] ^ poly[w-j];
        r = '0;
        for (int j = 0; j < w; j++) r[w-1-j] = d[len+j];
        o = r;
        if (ro) begin
            o = '0;
            for (int i = 0; i < w; i++) o[i] = r[w-1-i];
        end
        return o ^ xo;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (v16 && crc_ready) begin
                if (sb16.size() == 0) check("u16_unexpected_valid", 1, 0);
                else begin
                    me16 = sb16.pop_front();
                    check("u16_crc", out16, me16.crc);
                    check("u16_err", err16, me16.err);
                    check("u16_beats", beats16, me16.beats);
                end
            end
            if (v32 && crc_ready) begin
                if (sb32.size() == 0) check("u32_unexpected_valid", 1, 0);
                else begin
                    me32 = sb32.pop_front();
                    check("u32_crc", out32, me32.crc);
                    check("u32_err", err32, me32.err);
                    check("u32_beats", beats32, me32.beats);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; waits for in_ready, presents one beat and updates the model.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic ab);
        int t = 0;
        while (!rdy16 && t < 300) begin
            if (rand_rdy) crc_ready = ($urandom_range(0, 2) != 0);
            cyc(1);
            t++;
        end
        if (t >= 300) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1; in_data = d; in_last = last; in_abort = ab;
        if (ab) begin
            cur.delete();
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                sp16 = poly16; si16 = init16; sx16 = xor16; sri16 = refin16; sro16 = refout16; sce16 = chken16;
                sp32 = poly32; si32 = init32; sx32 = xor32; sri32 = refin32; sro32 = refout32; sce32 = chken32;
                in_frame = 1'b1;
            end
            cur.push_back(d);
            if (last) begin
                pe.crc   = ref_crc(16, {16'h0, sp16}, {16'h0, si16}, {16'h0, sx16}, sri16, sro16, cur);
                pe.err   = sce16 & (pe.crc[15:0] != chk16);
                pe.beats = 16'(cur.size());
                sb16.push_back(pe);
                pe.crc   = ref_crc(32, sp32, si32, sx32, sri32, sro32, cur);
                pe.err   = sce32 & (pe.crc != chk32);
                sb32.push_back(pe);
                cur.delete();
                in_frame = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0;
        if (last && !ab) check("latency_valid", {v32, v16}, 2'b11);
    endtask

    task automatic send_frame(input bq_t m, input int gap_max);
        for (int k = 0; k < m.size(); k++) begin
            if (gap_max > 0) cyc($urandom_range(0, gap_max));
            send_beat(m[k], k == m.size() - 1, 1'b0);
        end
    endtask

    task automatic cfg_ccitt();
        poly16 = 16'h1021; init16 = 16'hFFFF; xor16 = 16'h0; refin16 = 0; refout16 = 0; chken16 = 0;
    endtask

    task automatic drain();
        int t = 0;
        crc_ready = 1'b1;
        while ((sb16.size() != 0 || sb32.size() != 0) && t < 100) begin cyc(1); t++; end
        if (t >= 100) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        kat = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        cfg_ccitt(); chk16 = 0;
        poly32 = 32'h04C11DB7; init32 = 32'hFFFFFFFF; xor32 = 32'hFFFFFFFF;
        refin32 = 1; refout32 = 1; chken32 = 0; chk32 = 0;
        in_valid = 0; in_last = 0; in_abort = 0; in_data = 0; crc_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cyc(3);
        check("reset_in_ready", rdy16, 0);
        check("reset_valid", v16, 0);
        check("reset_out", out16, 0);
        check("reset_busy", busy16, 0);
        rst_n = 1'b1;
        check("in_ready_before_first_edge", rdy16, 0);
        cyc(1);
        check("in_ready_after_release", rdy16, 1);

        // Known answers: CRC-16/CCITT-FALSE and CRC-32.
        send_frame(kat, 0);
        check("kat_ccitt", out16, 16'h29B1);
        check("kat_crc32", out32, 32'hCBF43926);
        check("kat_beats", beats16, 9);
        cyc(2);
        poly16 = 16'h8005; init16 = 0; refin16 = 1; refout16 = 1;
        send_frame(kat, 0);
        check("kat_arc", out16, 16'hBB3D);
        cyc(2);

        // Checker mode.
        cfg_ccitt(); chken16 = 1; chk16 = 16'h29B1;
        send_frame(kat, 1);
        check("chk_match_err", err16, 0);
        cyc(2);
        chk16 = 16'h29B0;
        send_frame(kat, 0);
        check("chk_mismatch_err", err16, 1);
        cyc(2);
        chken16 = 0;
        send_frame(kat, 0);
        check("chk_disabled_err", err16, 0);
        cyc(2);

        // Backpressure on the result, with an abort attempt while in DONE.
        crc_ready = 0;
        send_frame(kat, 0);
        for (int i = 0; i < 5; i++) begin
            in_abort = (i == 2);
            cyc(1);
            check("bp_valid", v16, 1);
            check("bp_out", out16, 16'h29B1);
            check("bp_err", err16, 0);
            check("bp_in_ready", rdy16, 0);
        end
        in_abort = 0;
        crc_ready = 1;
        cyc(1);
        check("bp_release_valid", v16, 0);
        check("bp_release_in_ready", rdy16, 1);
        send_frame(kat, 0);
        check("b2b_out", out16, 16'h29B1);
        cyc(2);

        // Abort handling, then a frame with cfg_poly toggled mid-frame.
        for (int i = 0; i < 4; i++) send_beat(8'($urandom), 1'b0, 1'b0);
        send_beat(8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_valid", v16, 0);
            check("abort_busy", busy16, 0);
            cyc(1);
        end
        send_beat(8'h5A, 1'b1, 1'b1);
        cyc(1);
        check("idle_abort_no_valid", v16, 0);
        check("idle_abort_busy", busy16, 0);
        for (int k = 0; k < 9; k++) begin
            send_beat(kat[k], k == 8, 1'b0);
            poly16 = 16'($urandom);
        end
        check("post_abort_out", out16, 16'h29B1);
        check("post_abort_beats", beats16, 9);
        cyc(2);

        // Single-beat frame.
        cfg_ccitt();
        send_beat(8'h00, 1'b1, 1'b0);
        check("single_out", out16, 16'hE1F0);
        check("single_beats", beats16, 1);
        cyc(2);

        // Randomised frames, configs, gaps, aborts and result backpressure.
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len, ab_at;
            poly16 = 16'($urandom); init16 = 16'($urandom); xor16 = 16'($urandom);
            refin16 = 1'($urandom); refout16 = 1'($urandom); chken16 = 1'($urandom);
            poly32 = $urandom; init32 = $urandom; xor32 = $urandom;
            refin32 = 1'($urandom); refout32 = 1'($urandom); chken32 = 1'($urandom);
            len = $urandom_range(1, 12);
            frm.delete();
            for (int k = 0; k < len; k++) frm.push_back(8'($urandom));
            chk16 = $urandom_range(0, 1) ? ref_crc(16, {16'h0, poly16}, {16'h0, init16}, {16'h0, xor16},
                                                   refin16, refout16, frm) : 32'($urandom);
            chk32 = $urandom_range(0, 1) ? ref_crc(32, poly32, init32, xor32, refin32, refout32, frm)
                                         : $urandom;
            ab_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int k = 0; k < len; k++) begin
                cyc($urandom_range(0, 2));
                if (k == ab_at) begin
                    send_beat(8'($urandom), 1'b0, 1'b1);
                    break;
                end
                send_beat(frm[k], k == len - 1, 1'b0);
            end
        end
        rand_rdy = 1'b0;
        drain();
        cyc(2);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        cfg_ccitt();
        send_beat(8'h31, 1'b0, 1'b0);
        send_beat(8'h32, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy16, 0);
        check("arst_in_ready", rdy16, 0);
        check("arst_valid", v16, 0);
        check("arst_out", out16, 0);
        check("arst_beats", beats16, 0);
        cur.delete();
        in_frame = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        check("arst_no_result", v16, 0);
        send_frame(kat, 0);
        check("after_arst_out", out16, 16'h29B1);
        drain();
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
